// File: rtl/median_seq_ctrl.sv
// Streaming median of N unsigned samples: loads N samples, then runs partial
// bubble passes through one shared compare-exchange until the median settles.
//
// state | meaning
// IDLE  | waiting for the first sample of a set
// LOAD  | collecting samples 2..N into the register bank
// SORT  | one compare-exchange per cycle, median emitted on the last step
module median_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int N     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] di_i,
    input  logic             dsi_i,
    output logic [WIDTH-1:0] do_o,
    output logic             dso_o,
    output logic             busy_o
);

    if ((N < 3) || (N > 15) || ((N % 2) == 0)) begin : g_bad_n
        $error("median_seq_ctrl: N must be odd and within 3..15");
    end

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] P_LAST = IW'((N - 1) / 2);
    localparam logic [IW-1:0] LC_LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SORT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q [N];
    logic [WIDTH-1:0] r_d [N];
    logic [IW-1:0]    lc_q, lc_d;
    logic [IW-1:0]    p_q, p_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] do_q, do_d;
    logic             dso_q, dso_d;

    logic [IW-1:0]    i_nxt;
    logic [IW-1:0]    i_last;
    logic [WIDTH-1:0] mce_a, mce_b, mce_min, mce_max;

    // Single compare-exchange; operands are muxed from the bank by I.
    always_comb begin
        i_nxt   = i_q + IW'(1);
        i_last  = IW'(N - 2) - p_q;
        mce_a   = r_q[i_q];
        mce_b   = r_q[i_nxt];
        mce_max = (mce_a > mce_b) ? mce_a : mce_b;
        mce_min = (mce_a > mce_b) ? mce_b : mce_a;
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        lc_d    = lc_q;
        p_d     = p_q;
        i_d     = i_q;
        do_d    = do_q;
        dso_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dsi_i) begin
                    r_d[0]  = di_i;
                    lc_d    = IW'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (dsi_i) begin
                    r_d[lc_q] = di_i;
                    lc_d      = lc_q + IW'(1);
                    if (lc_q == LC_LAST) begin
                        p_d     = '0;
                        i_d     = '0;
                        state_d = S_SORT;
                    end
                end
            end
            S_SORT: begin
                r_d[i_q]   = mce_min;
                r_d[i_nxt] = mce_max;
                if (i_q == i_last) begin
                    i_d = '0;
                    if (p_q == P_LAST) begin
                        // The max of the last exchange is the (N+1)/2-th largest: the median.
                        do_d    = mce_max;
                        dso_d   = 1'b1;
                        lc_d    = '0;
                        p_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        p_d = p_q + IW'(1);
                    end
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int k = 0; k < N; k++) r_q[k] <= '0;
            lc_q    <= '0;
            p_q     <= '0;
            i_q     <= '0;
            do_q    <= '0;
            dso_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            lc_q    <= lc_d;
            p_q     <= p_d;
            i_q     <= i_d;
            do_q    <= do_d;
            dso_q   <= dso_d;
        end
    end

    assign do_o   = do_q;
    assign dso_o  = dso_q;
    assign busy_o = (state_q == S_SORT);

endmodule

// File: tb/tb_median_seq_ctrl.sv
// Directed and random checks of median_seq_ctrl with N=9, WIDTH=8.
module tb_median_seq_ctrl;

    localparam int N = 9;
    localparam int S = 30;

    typedef logic [7:0] set_t [N];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] di = '0;
    logic       dsi = 1'b0;
    logic [7:0] do_w;
    logic       dso_w;
    logic       busy_w;

    int errors = 0;
    int checks = 0;
    int dso_seen = 0;

    median_seq_ctrl #(.WIDTH(8), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .di_i  (di),
        .dsi_i (dsi),
        .do_o  (do_w),
        .dso_o (dso_w),
        .busy_o(busy_w)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] median_ref(input set_t s);
        set_t t;
        logic [7:0] tmp;
        t = s;
        for (int a = 0; a < N - 1; a++)
            for (int b = 0; b < N - 1 - a; b++)
                if (t[b] > t[b+1]) begin
                    tmp = t[b]; t[b] = t[b+1]; t[b+1] = tmp;
                end
        return t[N/2];
    endfunction

    task automatic send_sample(input logic [7:0] v);
        dsi = 1'b1;
        di  = v;
        @(posedge clk); #1;
        dsi = 1'b0;
        if (dso_w) dso_seen++;
    endtask

    task automatic load_set(input set_t s, input int max_gap);
        for (int k = 0; k < N; k++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(0, max_gap);
                repeat (g) begin
                    @(posedge clk); #1;
                    if (dso_w) dso_seen++;
                end
            end
            send_sample(s[k]);
        end
    endtask

    // Called at E0+1; returns at the first cycle with DSO high (lat = -1 on timeout).
    task automatic run_to_result(input bit junk, output int lat, output int bcnt,
                                 output logic [7:0] res);
        lat  = -1;
        bcnt = 0;
        res  = '0;
        for (int k = 0; k <= 60 && lat < 0; k++) begin
            if (dso_w) begin
                lat = k;
                res = do_w;
            end else begin
                if (busy_w) bcnt++;
                if (junk) begin
                    dsi = 1'b1;
                    di  = 8'h00;
                end
                @(posedge clk); #1;
            end
        end
        dsi = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            di  = 8'($urandom);
            dsi = 1'($urandom);
            #1;
            checks++;
            if ({do_w, dso_w, busy_w} !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold: do=%0d dso=%b busy=%b, required 0/0/0", do_w, dso_w, busy_w);
            end
            @(posedge clk); #1;
        end
        dsi   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        set_t s;
        int lat, bcnt;
        logic [7:0] res;
        s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        load_set(s, 0);
        checks++;
        if (busy_w !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_start: busy=%b, required 1", busy_w);
        end
        run_to_result(1'b0, lat, bcnt, res);
        checks++;
        if (lat !== S) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required %0d", lat, S);
        end
        checks++;
        if (bcnt !== S) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, required %0d", bcnt, S);
        end
        checks++;
        if (res !== 8'd5) begin
            errors++;
            $display("FAIL basic_median: got %0d, required 5", res);
        end
        checks++;
        if (busy_w !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_end: busy=%b, required 0", busy_w);
        end
        @(posedge clk); #1;
        checks++;
        if (dso_w !== 1'b0 || do_w !== 8'd5) begin
            errors++;
            $display("FAIL basic_dso_drop: dso=%b do=%0d, required 0 and 5", dso_w, do_w);
        end
    endtask

    task automatic test_extremes();
        set_t s;
        int lat, bcnt;
        logic [7:0] res;
        s = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
        load_set(s, 0);
        run_to_result(1'b0, lat, bcnt, res);
        checks++;
        if (res !== 8'd128 || lat !== S) begin
            errors++;
            $display("FAIL extremes_median: got %0d lat %0d, required 128 lat %0d", res, lat, S);
        end
        for (int k = 0; k < N; k++) s[k] = 8'd7;
        load_set(s, 3);
        run_to_result(1'b0, lat, bcnt, res);
        checks++;
        if (res !== 8'd7 || lat !== S) begin
            errors++;
            $display("FAIL dup_gaps_median: got %0d lat %0d, required 7 lat %0d", res, lat, S);
        end
    endtask

    // Ends on the DSO cycle so that test_back_to_back starts loading immediately.
    task automatic test_sort_ignore();
        set_t s;
        int lat, bcnt;
        logic [7:0] res;
        @(posedge clk); #1;
        s = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        load_set(s, 0);
        run_to_result(1'b1, lat, bcnt, res);
        checks++;
        if (res !== 8'd50) begin
            errors++;
            $display("FAIL ignore_median: got %0d, required 50", res);
        end
        checks++;
        if (lat !== S) begin
            errors++;
            $display("FAIL ignore_latency: got %0d, required %0d", lat, S);
        end
    endtask

    task automatic test_back_to_back();
        set_t s;
        int lat, bcnt;
        logic [7:0] res;
        s = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_sample(s[0]);
        checks++;
        if (dso_w !== 1'b0) begin
            errors++;
            $display("FAIL b2b_dso_drop: dso=%b, required 0", dso_w);
        end
        for (int k = 1; k < N; k++) send_sample(s[k]);
        run_to_result(1'b0, lat, bcnt, res);
        checks++;
        if (res !== 8'd5 || lat !== S) begin
            errors++;
            $display("FAIL b2b_median: got %0d lat %0d, required 5 lat %0d", res, lat, S);
        end
    endtask

    task automatic test_reset_mid();
        set_t s;
        int lat, bcnt, extra;
        logic [7:0] res;
        @(posedge clk); #1;
        s = '{8'd200, 8'd210, 8'd220, 8'd230, 8'd240, 8'd250, 8'd201, 8'd202, 8'd203};
        load_set(s, 0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({do_w, dso_w, busy_w} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_sort: do=%0d dso=%b busy=%b, required 0/0/0", do_w, dso_w, busy_w);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) send_sample(8'd255);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        s = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        load_set(s, 0);
        run_to_result(1'b0, lat, bcnt, res);
        checks++;
        if (res !== 8'd50 || lat !== S) begin
            errors++;
            $display("FAIL reset_mid_median: got %0d lat %0d, required 50 lat %0d", res, lat, S);
        end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dso_w) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL reset_mid_single_dso: %0d extra strobes, required 0", extra);
        end
    endtask

    task automatic test_random();
        set_t s;
        int lat, bcnt;
        logic [7:0] res, exp_v;
        bit stop;
        stop = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 1000 && !stop; n++) begin
            for (int k = 0; k < N; k++)
                s[k] = 8'($urandom_range(0, (n % 3 == 0) ? 3 : 255));
            exp_v = median_ref(s);
            dso_seen = 0;
            load_set(s, 0);
            run_to_result(1'b0, lat, bcnt, res);
            checks++;
            if (res !== exp_v || lat !== S || dso_seen !== 0) begin
                errors++;
                stop = 1'b1;
                $display("FAIL random_set %0d: got %0d lat %0d stray %0d, required %0d lat %0d stray 0",
                         n, res, lat, dso_seen, exp_v, S);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_sort_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
